ex_mem_elastic_stage: RTL and testbench
=======================================

// Module: ex_mem_elastic_stage
// PURPOSE
// Parametrised EX->MEM pipeline register with valid/ready handshake, a 2-entry skid buffer and flush.
// Sits between the EX datapath/forwarding mux and the MEM stage (data memory, branch resolve).
// Lets MEM stall (e.g. multi-cycle memory) without a combinational ready path back into EX.
// Lets branch resolution kill younger work. Carries Instruction for the forwarding unit.
// PARAMETERS
// DATA_W      32  width of ALU_Result, Write_Data, Branch_Dest, Instruction
// REG_ADDR_W  5   width of Write_Register
// CTRL_W      5   control bundle width {RegWrite,MemtoReg,Branch,MemRead,MemWrite}, MSB first
// PORTS
// Clk             in   1           rising-edge clock
// Reset_n         in   1           asynchronous, active-low reset
// Valid_EX        in   1           EX presents an instruction
// Ready_EX        out  1           stage can accept; registered, never depends on Ready_MEM same-cycle
// Flush           in   1           kill incoming and skid entry (branch taken in MEM)
// Ctrl_EX         in   CTRL_W      control bundle from EX
// Branch_Dest_EX  in   DATA_W      branch target
// Zero_EX         in   1           ALU zero flag
// ALU_Result_EX   in   DATA_W      ALU result / memory address
// Write_Data_EX   in   DATA_W      forwarded rt value (store data)
// Write_Reg_EX    in   REG_ADDR_W  destination register
// Instruction_EX  in   DATA_W      instruction word, for forwarding unit
// Valid_MEM       out  1           output entry valid
// Ready_MEM       in   1           MEM consumes output entry this cycle
// Ctrl_MEM, Branch_Dest_MEM, Zero_MEM, ALU_Result_MEM, Write_Data_MEM, Write_Reg_MEM, Instruction_MEM
//                 out  as _EX      registered copies of the output entry
// BEHAVIOUR
// - Transfer in: Valid_EX & Ready_EX & ~Flush. Transfer out: Valid_MEM & Ready_MEM.
// - Two entries: OUT (drives *_MEM) and SKID. Occupancy FSM:
//   EMPTY -in-> ONE
//   ONE   -in&out-> ONE (OUT<=incoming) | -in&~out-> TWO (SKID<=incoming) | -out&~in-> EMPTY
//   TWO   -out-> ONE (OUT<=SKID). No accept in TWO: Ready_EX=0.
// - Ready_EX = (state!=TWO), registered from next-state. Latency: 1 cycle EX->MEM when unstalled.
//   Full throughput with Ready_MEM held high.
// - Flush (same cycle): incoming dropped; SKID invalidated (TWO->ONE, or EMPTY if OUT also leaves).
//   OUT entry kept: it is the older, resolving instruction.
// - Flush & out in ONE/TWO with SKID: OUT does not reload from SKID; state->EMPTY.
// - Ctrl_MEM forced to 0 whenever Valid_MEM=0 (no RegWrite/MemWrite on a bubble).
// - Data fields hold their last value when invalid; no X-propagation requirement beyond reset.
// - Reset (async, any cycle incl. mid-stall): state EMPTY, Valid_MEM=0, Ready_EX=1, every *_MEM output 0.
//   Deassertion is synchronised by the top level.
// - Order preserved: SKID entry is always younger than OUT. No entry is duplicated or lost except by Flush.
// STRUCTURE
// - Shared pipeline package: CTRL_W and control bit indices (CTRL_REGWRITE=4 ... CTRL_MEMWRITE=0),
//   state encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2, default NOP instruction 32'h0.
// - One sub-module: pipe_skid_entry, a parametrised payload register with load enable and async clear,
//   instantiated twice (OUT, SKID). FSM and muxing stay in this module.
// TESTING
// 1 Reset: Reset_n=0 mid-TWO state -> next edge-independent: Valid_MEM=0, Ready_EX=1, Ctrl_MEM=0, ALU_Result_MEM=0.
// 2 Stream: Ready_MEM=1, Valid_EX=1, ALU_Result 1,2,3,4 on consecutive cycles -> appear 1 cycle later,
//   Valid_MEM=1 throughout, Ready_EX stays 1.
// 3 Stall: A,B,C sent, Ready_MEM=0 after A -> OUT=A, SKID=B, Ready_EX=0; C held by EX.
//   Release -> A,B,C emitted in order, none duplicated.
// 4 Flush: state TWO (OUT=A beq, SKID=B), Flush=1, Valid_EX=1 (C), Ready_MEM=0 ->
//   OUT=A kept, B and C dropped, Ready_EX=1.
// 5 Flush+drain: state TWO, Flush=1 & Ready_MEM=1 -> A consumed, state EMPTY, Valid_MEM=0, Ctrl_MEM=5'b0.
// 6 Bubble gating: Valid_EX=1, Ctrl_EX=5'b10000 with Flush=1 -> Valid_MEM=0, Ctrl_MEM[RegWrite]=0.
//   Random valid/ready scoreboard: 10k cycles, no loss/reorder.

Source files
------------

// File: rtl/ex_mem_elastic_stage_pkg.sv
// Shared EX/MEM pipeline definitions: control bundle layout, occupancy encoding, NOP word.
package ex_mem_elastic_stage_pkg;

  // Control bundle {RegWrite, MemtoReg, Branch, MemRead, MemWrite}, MSB first
  localparam int unsigned CTRL_BUNDLE_W = 5;
  localparam int unsigned CTRL_REGWRITE = 4;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_BRANCH   = 2;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMWRITE = 0;

  // Stage occupancy: how many of the OUT/SKID entries hold live instructions
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/pipe_skid_entry.sv
// Payload register with load enable and asynchronous clear; one pipeline slot.
module pipe_skid_entry #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture payload on load; clear to zero on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_mem_elastic_stage.sv
// EX->MEM elastic pipeline register: valid/ready handshake, 2-entry skid buffer, flush.
// Ready_EX is registered so MEM stalls never form a combinational path back into EX.
import ex_mem_elastic_stage_pkg::*;

module ex_mem_elastic_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = CTRL_BUNDLE_W
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Valid_EX,
  output logic                  Ready_EX,
  input  logic                  Flush,
  input  logic [CTRL_W-1:0]     Ctrl_EX,
  input  logic [DATA_W-1:0]     Branch_Dest_EX,
  input  logic                  Zero_EX,
  input  logic [DATA_W-1:0]     ALU_Result_EX,
  input  logic [DATA_W-1:0]     Write_Data_EX,
  input  logic [REG_ADDR_W-1:0] Write_Reg_EX,
  input  logic [DATA_W-1:0]     Instruction_EX,
  output logic                  Valid_MEM,
  input  logic                  Ready_MEM,
  output logic [CTRL_W-1:0]     Ctrl_MEM,
  output logic [DATA_W-1:0]     Branch_Dest_MEM,
  output logic                  Zero_MEM,
  output logic [DATA_W-1:0]     ALU_Result_MEM,
  output logic [DATA_W-1:0]     Write_Data_MEM,
  output logic [REG_ADDR_W-1:0] Write_Reg_MEM,
  output logic [DATA_W-1:0]     Instruction_MEM
);

  localparam int unsigned PAY_W = CTRL_W + 4 * DATA_W + 1 + REG_ADDR_W;

  occ_e             r_state;
  occ_e             w_state_d;
  logic             r_valid;
  logic             r_ready;
  logic             w_xfer_in;
  logic             w_xfer_out;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_out_from_skid;
  logic [PAY_W-1:0] w_in_payload;
  logic [PAY_W-1:0] w_out_d;
  logic [PAY_W-1:0] w_out_q;
  logic [PAY_W-1:0] w_skid_q;
  logic [CTRL_W-1:0] w_ctrl_out;

  assign w_in_payload = {Ctrl_EX, Branch_Dest_EX, Zero_EX, ALU_Result_EX, Write_Data_EX,
                         Write_Reg_EX, Instruction_EX};

  assign w_xfer_in  = Valid_EX & r_ready & ~Flush;
  assign w_xfer_out = r_valid & Ready_MEM;

  // Occupancy next-state and entry load decisions
  always_comb begin
    w_state_d       = r_state;
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_out_from_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_xfer_in) begin
          w_state_d  = ONE;
          w_load_out = 1'b1;
        end
      end
      ONE: begin
        if (w_xfer_in && w_xfer_out) begin
          w_load_out = 1'b1;
        end else if (w_xfer_in) begin
          w_state_d   = TWO;
          w_load_skid = 1'b1;
        end else if (w_xfer_out) begin
          w_state_d = EMPTY;
        end
      end
      TWO: begin
        // Flush kills the younger SKID entry; OUT is the resolving instruction and stays
        if (Flush) begin
          w_state_d = w_xfer_out ? EMPTY : ONE;
        end else if (w_xfer_out) begin
          w_state_d       = ONE;
          w_load_out      = 1'b1;
          w_out_from_skid = 1'b1;
        end
      end
      default: w_state_d = EMPTY;
    endcase
  end

  assign w_out_d = w_out_from_skid ? w_skid_q : w_in_payload;

  // State plus valid/ready flags, all registered from the next state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_valid <= (w_state_d != EMPTY);
      r_ready <= (w_state_d != TWO);
    end
  end

  pipe_skid_entry #(
    .WIDTH (PAY_W)
  ) u_out_entry (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_load  (w_load_out),
    .i_d     (w_out_d),
    .o_q     (w_out_q)
  );

  pipe_skid_entry #(
    .WIDTH (PAY_W)
  ) u_skid_entry (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_load  (w_load_skid),
    .i_d     (w_in_payload),
    .o_q     (w_skid_q)
  );

  assign {w_ctrl_out, Branch_Dest_MEM, Zero_MEM, ALU_Result_MEM, Write_Data_MEM,
          Write_Reg_MEM, Instruction_MEM} = w_out_q;

  // A bubble must never write the register file or memory
  assign Ctrl_MEM  = r_valid ? w_ctrl_out : '0;
  assign Valid_MEM = r_valid;
  assign Ready_EX  = r_ready;

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
// Scoreboard bench for ex_mem_elastic_stage: the driver keeps the stage contents as a
// queue of in-flight instructions, the monitor pops and compares on every MEM handshake.
module tb_ex_mem_elastic_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int PW = CW + 4 * DW + 1 + RW;

  logic          Clk;
  logic          Reset_n;
  logic          Valid_EX;
  logic          Ready_EX;
  logic          Flush;
  logic [CW-1:0] Ctrl_EX;
  logic [DW-1:0] Branch_Dest_EX;
  logic          Zero_EX;
  logic [DW-1:0] ALU_Result_EX;
  logic [DW-1:0] Write_Data_EX;
  logic [RW-1:0] Write_Reg_EX;
  logic [DW-1:0] Instruction_EX;
  logic          Valid_MEM;
  logic          Ready_MEM;
  logic [CW-1:0] Ctrl_MEM;
  logic [DW-1:0] Branch_Dest_MEM;
  logic          Zero_MEM;
  logic [DW-1:0] ALU_Result_MEM;
  logic [DW-1:0] Write_Data_MEM;
  logic [RW-1:0] Write_Reg_MEM;
  logic [DW-1:0] Instruction_MEM;

  ex_mem_elastic_stage #(
    .DATA_W     (DW),
    .REG_ADDR_W (RW),
    .CTRL_W     (CW)
  ) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .Valid_EX        (Valid_EX),
    .Ready_EX        (Ready_EX),
    .Flush           (Flush),
    .Ctrl_EX         (Ctrl_EX),
    .Branch_Dest_EX  (Branch_Dest_EX),
    .Zero_EX         (Zero_EX),
    .ALU_Result_EX   (ALU_Result_EX),
    .Write_Data_EX   (Write_Data_EX),
    .Write_Reg_EX    (Write_Reg_EX),
    .Instruction_EX  (Instruction_EX),
    .Valid_MEM       (Valid_MEM),
    .Ready_MEM       (Ready_MEM),
    .Ctrl_MEM        (Ctrl_MEM),
    .Branch_Dest_MEM (Branch_Dest_MEM),
    .Zero_MEM        (Zero_MEM),
    .ALU_Result_MEM  (ALU_Result_MEM),
    .Write_Data_MEM  (Write_Data_MEM),
    .Write_Reg_MEM   (Write_Reg_MEM),
    .Instruction_MEM (Instruction_MEM)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned    n_tests = 0;
  int unsigned    n_fail  = 0;
  logic [PW-1:0]  sb_q[$];      // instructions held by the stage, oldest first
  logic           mon_en  = 1'b0;
  logic [PW-1:0]  ex_item;
  logic           ex_pending = 1'b0;
  logic [PW-1:0]  act_payload;

  assign act_payload = {Ctrl_MEM, Branch_Dest_MEM, Zero_MEM, ALU_Result_MEM, Write_Data_MEM,
                        Write_Reg_MEM, Instruction_MEM};

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_item();
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic          z;
    c = CW'($urandom);
    r = RW'($urandom);
    z = 1'($urandom);
    return {c, $urandom, z, $urandom, $urandom, r, $urandom};
  endfunction

  // Monitor: compare flags against occupancy and pop on each MEM handshake
  always @(negedge Clk) begin
    if (mon_en) begin
      check("valid_mem", PW'(Valid_MEM), PW'(sb_q.size() != 0));
      check("ready_ex", PW'(Ready_EX), PW'(sb_q.size() < 2));
      if (!Valid_MEM) check("bubble_ctrl", PW'(Ctrl_MEM), '0);
      if (Valid_MEM && Ready_MEM) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", PW'(1), PW'(0));
        end else begin
          check("payload", act_payload, sb_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1. Probabilities in percent.
  task automatic run_cycle(input int p_valid, input int p_ready, input int p_flush);
    int  occ;
    bit  out_c;
    bit  acc_c;
    if (!ex_pending && ($urandom_range(99) < p_valid)) begin
      ex_item    = rand_item();
      ex_pending = 1'b1;
    end
    Valid_EX  = ex_pending;
    {Ctrl_EX, Branch_Dest_EX, Zero_EX, ALU_Result_EX, Write_Data_EX, Write_Reg_EX,
     Instruction_EX} = ex_item;
    Ready_MEM = ($urandom_range(99) < p_ready);
    Flush     = ($urandom_range(99) < p_flush);
    occ   = sb_q.size();
    out_c = (occ > 0) && Ready_MEM;
    acc_c = Valid_EX && (occ < 2) && !Flush;
    @(posedge Clk);
    #1;
    // Flush removes everything younger than the entry currently presented to MEM
    if (Flush) begin
      if (out_c) sb_q.delete();
      else while (sb_q.size() > 1) void'(sb_q.pop_back());
    end
    if (acc_c) begin
      sb_q.push_back(ex_item);
      ex_pending = 1'b0;
    end else if (Flush) begin
      ex_pending = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, PW'(Valid_MEM), PW'(0));
    check({tag, "_ready"}, PW'(Ready_EX), PW'(1));
    check({tag, "_ctrl"}, PW'(Ctrl_MEM), PW'(0));
    check({tag, "_alu"}, PW'(ALU_Result_MEM), PW'(0));
    check({tag, "_payload"}, act_payload, '0);
  endtask

  initial begin
    Reset_n   = 1'b0;
    Valid_EX  = 1'b0;
    Flush     = 1'b0;
    Ready_MEM = 1'b0;
    ex_item   = '0;
    {Ctrl_EX, Branch_Dest_EX, Zero_EX, ALU_Result_EX, Write_Data_EX, Write_Reg_EX,
     Instruction_EX} = '0;
    #12;
    check_reset_outputs("reset_init");
    @(negedge Clk);
    Reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge Clk);
    #1;

    // Full-rate stream
    for (int i = 0; i < 8; i++) run_cycle(100, 100, 0);
    // Stall into TWO, then release
    for (int i = 0; i < 4; i++) run_cycle(100, 0, 0);
    for (int i = 0; i < 5; i++) run_cycle(0, 100, 0);
    // Flush while full and MEM stalled
    for (int i = 0; i < 3; i++) run_cycle(100, 0, 0);
    run_cycle(100, 0, 100);
    for (int i = 0; i < 3; i++) run_cycle(0, 100, 0);
    // Flush while full and MEM draining
    for (int i = 0; i < 3; i++) run_cycle(100, 0, 0);
    run_cycle(0, 100, 100);
    for (int i = 0; i < 2; i++) run_cycle(0, 0, 0);
    // Incoming valid under flush must stay a bubble
    for (int i = 0; i < 4; i++) run_cycle(100, 100, 100);
    for (int i = 0; i < 2; i++) run_cycle(0, 100, 0);

    // Randomised traffic with changing valid/ready/flush mixes
    for (int blk = 0; blk < 20; blk++) begin
      int pv;
      int pr;
      int pf;
      pv = 20 + int'($urandom_range(80));
      pr = 10 + int'($urandom_range(90));
      pf = int'($urandom_range(15));
      for (int i = 0; i < 500; i++) run_cycle(pv, pr, pf);
    end

    // Drain and confirm nothing is left behind
    for (int i = 0; i < 4; i++) run_cycle(0, 100, 0);
    check("drain_empty", PW'(sb_q.size()), PW'(0));

    // Asynchronous reset while full
    for (int i = 0; i < 3; i++) run_cycle(100, 0, 0);
    check("pre_reset_full", PW'(sb_q.size()), PW'(2));
    mon_en = 1'b0;
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    sb_q.delete();
    ex_pending = 1'b0;
    Valid_EX   = 1'b0;
    Flush      = 1'b0;
    @(posedge Clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge Clk);
    Reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 6; i++) run_cycle(100, 100, 0);
    for (int i = 0; i < 3; i++) run_cycle(0, 100, 0);
    check("final_empty", PW'(sb_q.size()), PW'(0));

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
